// File: rtl/mem_bus_arbiter4_if.sv
// mem_bus_arbiter4_if
// Bundles the client request/response signals and the external memory bus
// used by mem_bus_arbiter4.
//   master : arbiter view (takes client requests and memory responses,
//            drives client completions and the memory strobes)
//   slave  : environment view (clients plus memory device)
// Client i uses slice [i*ADDR_W +: ADDR_W] of req_addr and
// [i*DATA_W +: DATA_W] of req_wdata.
interface mem_bus_arbiter4_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [3:0]          req_rd;
  logic [3:0]          req_wr;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_wdata;
  logic [3:0]          cli_ack;
  logic [3:0]          cli_err;
  logic [DATA_W-1:0]   cli_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_rd;
  logic                mem_wr;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;
  logic                busy;
  logic [1:0]          owner;

  modport master (
    input  req_rd, req_wr, req_addr, req_wdata, mem_rdata, mem_ack,
    output cli_ack, cli_err, cli_rdata, mem_addr, mem_wdata, mem_rd, mem_wr,
           busy, owner
  );

  modport slave (
    output req_rd, req_wr, req_addr, req_wdata, mem_rdata, mem_ack,
    input  cli_ack, cli_err, cli_rdata, mem_addr, mem_wdata, mem_rd, mem_wr,
           busy, owner
  );
endinterface

// File: rtl/mem_bus_arbiter4.sv
// mem_bus_arbiter4
// Shares one external memory bus between four ring-buffer clients.
// Requests are granted round-robin, one memory transaction at a time; a
// watchdog aborts a WAIT that lasts TIMEOUT cycles without mem_ack.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : mem_bus_arbiter4_if.master
//          req_rd/req_wr/req_addr/req_wdata  per-client requests (level)
//          cli_ack/cli_err/cli_rdata         per-client completion pulses
//          mem_addr/mem_wdata/mem_rd/mem_wr  memory strobes (registered)
//          mem_rdata/mem_ack                 memory response
//          busy/owner                        status
module mem_bus_arbiter4 #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter4_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t              state;
  logic [1:0]          rr_ptr;
  logic [7:0]          timer;
  logic                op_rd;
  logic                op_wr;
  logic                done_err;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;

  logic [3:0]          pend;
  logic [1:0]          scan_idx;
  logic [1:0]          grant_idx;
  logic                grant_vld;

  // Round-robin pick: scan from the farthest offset down so the client
  // closest to rr_ptr overwrites the others and wins.
  always_comb begin
    pend      = bus.req_rd | bus.req_wr;
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    scan_idx  = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      scan_idx  = rr_ptr + 2'(k);
      grant_vld = grant_vld | pend[scan_idx];
      grant_idx = pend[scan_idx] ? scan_idx : grant_idx;
    end
  end

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= 2'd0;
      timer         <= 8'd0;
      op_rd         <= 1'b0;
      op_wr         <= 1'b0;
      done_err      <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      rdata_q       <= '0;
      bus.owner     <= 2'd0;
      bus.busy      <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cli_ack   <= 4'b0000;
      bus.cli_err   <= 4'b0000;
      bus.cli_rdata <= '0;
    end else begin
      bus.cli_ack <= 4'b0000;
      bus.cli_err <= 4'b0000;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            bus.owner <= grant_idx;
            op_rd     <= bus.req_rd[grant_idx];
            op_wr     <= bus.req_wr[grant_idx];
            lat_addr  <= bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            lat_wdata <= bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            bus.busy  <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            state     <= S_IDLE;
          end
        end
        S_ISSUE: begin
          bus.mem_addr  <= lat_addr;
          bus.mem_wdata <= lat_wdata;
          timer         <= 8'd0;
          if (op_rd && op_wr) begin
            // Read and write at once has no meaning: fail without a strobe.
            done_err <= 1'b1;
            state    <= S_DONE;
          end else begin
            bus.mem_rd <= op_rd;
            bus.mem_wr <= op_wr;
            done_err   <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // mem_ack is tested first so an ack on the expiry cycle still wins.
          if (bus.mem_ack) begin
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            rdata_q    <= op_rd ? bus.mem_rdata : rdata_q;
            done_err   <= 1'b0;
            state      <= S_DONE;
          end else if (timer == TIMER_LAST) begin
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            done_err   <= 1'b1;
            state      <= S_DONE;
          end else begin
            timer      <= timer + 8'd1;
            state      <= S_WAIT;
          end
        end
        S_DONE: begin
          if (done_err) begin
            bus.cli_err <= 4'b0001 << bus.owner;
          end else begin
            bus.cli_ack   <= 4'b0001 << bus.owner;
            bus.cli_rdata <= op_rd ? rdata_q : bus.cli_rdata;
          end
          timer    <= 8'd0;
          rr_ptr   <= bus.owner + 2'd1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter4.md
Name: mem_bus_arbiter4

Overview:
- Shares the single external memory bus of the dual MIL/SPI core between four ring-buffer clients. The clients are the RING2_0..RING2_3 queues, each mapped to a 64-word window.
- Arbitrates word-wide read/write requests round-robin, sequences one memory transaction at a time, and returns data and completion per client.
- Aborts a hung transaction with a watchdog so that one stalled memory access cannot starve the MIL and SPI paths.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- TIMEOUT, 64, maximum WAIT cycles before abort; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_rd  in  4  per-client read request; level signal, held until ack/err.
- req_wr  in  4  per-client write request; level signal, held until ack/err.
- req_addr  in  4*ADDR_W  per-client address; client i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  4*DATA_W  per-client write data; same slicing as req_addr.
- cli_ack  out  4  one-cycle completion pulse, one-hot.
- cli_err  out  4  one-cycle error pulse, one-hot.
- cli_rdata  out  DATA_W  read data; valid in the cli_ack cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion pulse.
- busy  out  1  high in ISSUE/WAIT/DONE.
- owner  out  2  index of the current or last granted client.

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE, rr_ptr=0, owner=0, timer=0, all other outputs 0. Strobes drop immediately and any in-flight transaction is discarded without ack or err.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Pending vector p[i]=req_rd[i]|req_wr[i].
  - Grant the first set p[i] scanning i = rr_ptr, rr_ptr+1, ... mod 4.
  - Latch owner, addr, wdata and op; go to ISSUE. No pending requests -> stay in IDLE.
- ISSUE (1 cycle):
  - Drive mem_addr and mem_wdata; assert mem_rd or mem_wr; go to WAIT.
  - Illegal op (req_rd & req_wr both set at grant): no strobe is asserted; go to DONE with err.
- WAIT:
  - Strobe, address and write data are held stable; timer increments each cycle.
  - mem_ack=1 -> drop strobe, capture mem_rdata (reads only), go to DONE with ack.
  - timer reaches TIMEOUT-1 with mem_ack=0 -> drop strobe, go to DONE with err.
  - mem_ack in the same cycle as expiry -> ack wins.
- DONE (1 cycle):
  - Pulse cli_ack[owner] or cli_err[owner]; cli_rdata is valid with ack.
  - Clear timer; set rr_ptr=owner+1 mod 4 (error or not); go to IDLE.
- cli_rdata holds its value until the next read completion; writes do not change it.
- Client rule: deassert req_rd/req_wr in the cycle after the ack/err pulse. IDLE samples requests no earlier than one cycle after DONE, so a single request is never serviced twice.
- Request input changes after grant are ignored; latched values are used.
- A client that drops its request before grant is simply skipped.
- Latency:
  - Request seen in IDLE at cycle N -> strobe at N+1.
  - mem_ack at cycle M -> cli_ack at M+1 -> next strobe no earlier than M+3.
  - Minimum transaction is 4 cycles (ISSUE, WAIT with ack, DONE, IDLE).
- Fairness: with all four clients continuously requesting, grants rotate 0,1,2,3,0,...; worst-case wait is 3 transactions.
- busy=0 only in IDLE. owner is valid from ISSUE until the next grant.

Test Plan:
- Single read: client 2 requests read at 16'h0085; memory acks 2 cycles after the strobe with 16'hAB45 -> mem_addr=16'h0085, mem_rd pulse 3 cycles long, cli_ack=4'b0100, cli_rdata=16'hAB45 one cycle after mem_ack.
- Round-robin: all four clients request writes continuously (wdata=16'h0001..0004) -> mem_wr order clients 0,1,2,3,0. Each client gets exactly one cli_ack per rotation, and each mem_wdata matches its client.
- Timeout (TIMEOUT=8): client 1 reads and memory never acks -> mem_rd is high exactly 8 cycles, then cli_err=4'b0010 and no cli_ack. Client 2 is granted next.
- Ack on expiry cycle: mem_ack coincides with timer=TIMEOUT-1 -> cli_ack pulse, no cli_err, data captured.
- Illegal op: client 3 asserts req_rd and req_wr together -> no mem_rd/mem_wr, cli_err=4'b1000 two cycles after grant, rr_ptr advances to 0.
- Reset mid-WAIT: assert rst while mem_wr=1 -> mem_wr, busy, cli_ack and cli_err are 0 without waiting for a clock edge. After release, a pending request from client 0 is granted first.
